uart_mux_tx: RTL and testbench

- Transmit-side counterpart to the UART demux that feeds the game loader and button registers.
- Accepts (address, data) pairs from on-chip sources such as loader status, RAM-fail flag and debug taps, and queues them in a small FIFO.
- Serializes each pair onto UART_TXD as a 3-byte 8N1 packet: address, data, checksum.
- Replaces the constant-high UART_TXD tie-off at top level so the host can read back status.

---
 rtl/uart_mux_tx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_mux_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mux_tx.sv
// uart_mux_tx
// Queues (address, data) pairs from on-chip status sources and sends each
// one to the host as a 3-byte 8N1 packet: address, data, and then
// (address + data) mod 256. Bytes are sent LSB first. One idle-high cycle
// separates back-to-back packets.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   in_valid_i    the source presents a packet
//   in_ready_o    the FIFO can accept; a transfer occurs on valid && ready
//   in_addr_i     packet address byte
//   in_data_i     packet data byte
//   txd_o         UART serial output, idle high
//   busy_o        the serializer is outside IDLE
//   tx_done_o     one-cycle pulse when a packet's final stop bit completes
//   fifo_level_o  packets queued, not counting the one in flight
module uart_mux_tx #(
  parameter int CLKS_PER_BIT = 186,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [7:0]                    in_addr_i,
  input  logic [7:0]                    in_data_i,
  output logic                          txd_o,
  output logic                          busy_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   BitLast   = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   LevelFull = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    addrMem [FIFO_DEPTH];
  logic [7:0]    dataMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic          push, pop;

  // Serializer state
  state_t        state_q, state_d;
  logic [15:0]   bitCnt_q, bitCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [1:0]    byteIdx_q, byteIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    pktData_q, pktData_d;
  logic [7:0]    pktSum_q, pktSum_d;
  logic          doneStage_q, doneStage_d;
  logic          lineBit;
  logic          bitLast;

  // Registered outputs
  logic          txd_q, busy_q, txDone_q;

  assign in_ready_o   = (count_q != LevelFull);
  assign push         = in_valid_i && in_ready_o;
  assign fifo_level_o = count_q;
  assign txd_o        = txd_q;
  assign busy_o       = busy_q;
  assign tx_done_o    = txDone_q;
  assign bitLast      = (bitCnt_q == BitLast);

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr_q] <= in_addr_i;
      dataMem[wrPtr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      bitIdx_q    <= '0;
      byteIdx_q   <= '0;
      shift_q     <= '0;
      pktData_q   <= '0;
      pktSum_q    <= '0;
      doneStage_q <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      txDone_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      bitIdx_q    <= bitIdx_d;
      byteIdx_q   <= byteIdx_d;
      shift_q     <= shift_d;
      pktData_q   <= pktData_d;
      pktSum_q    <= pktSum_d;
      doneStage_q <= doneStage_d;
      // The line and busy lag the state by one cycle, so a push at edge N
      // reaches the line at edge N+2. tx_done follows one cycle later
      // still, rising on the edge where the last stop bit ends.
      txd_q       <= lineBit;
      busy_q      <= (state_q != IDLE);
      txDone_q    <= doneStage_q;
    end
  end

  always_comb begin
    lineBit = 1'b1;
    case (state_q)
      START:   lineBit = 1'b0;
      DATA:    lineBit = shift_q[0];
      default: lineBit = 1'b1;
    endcase
  end

  // Next-state logic. The bit counter restarts at every bit boundary, so
  // timing error cannot build up across a packet.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    bitIdx_d    = bitIdx_q;
    byteIdx_d   = byteIdx_q;
    shift_d     = shift_q;
    pktData_d   = pktData_q;
    pktSum_d    = pktSum_q;
    doneStage_d = 1'b0;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = addrMem[rdPtr_q];
          pktData_d = dataMem[rdPtr_q];
          pktSum_d  = addrMem[rdPtr_q] + dataMem[rdPtr_q];
          byteIdx_d = '0;
          bitCnt_d  = '0;
          state_d   = START;
        end
      end

      START: begin
        if (bitLast) begin
          bitCnt_d = '0;
          bitIdx_d = '0;
          state_d  = DATA;
        end else begin
          bitCnt_d = bitCnt_q + 16'd1;
        end
      end

      DATA: begin
        if (bitLast) begin
          bitCnt_d = '0;
          shift_d  = {1'b0, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          bitCnt_d = bitCnt_q + 16'd1;
        end
      end

      STOP: begin
        if (bitLast) begin
          bitCnt_d = '0;
          if (byteIdx_q != 2'd2) begin
            // Start the next byte of the same packet with no idle gap.
            shift_d   = (byteIdx_q == 2'd0) ? pktData_q : pktSum_q;
            byteIdx_d = byteIdx_q + 2'd1;
            state_d   = START;
          end else begin
            doneStage_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          bitCnt_d = bitCnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_mux_tx.sv
// Testbench for uart_mux_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A table of single packets checks latency, framing, checksum wrap and
// tx_done timing. Hand-written sequences cover backpressure, a push and pop
// in the same cycle, and a reset in the middle of a frame.
module tb_uart_mux_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready_o;
  logic [7:0] in_addr;
  logic [7:0] in_data;
  logic       txd_o;
  logic       busy_o;
  logic       tx_done_o;
  logic [2:0] fifo_level_o;

  int passCount;
  int checkCount;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] sum;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] bpAddr [6];
  logic [7:0] bpData [6];

  uart_mux_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .in_addr_i   (in_addr),
    .in_data_i   (in_data),
    .txd_o       (txd_o),
    .busy_o      (busy_o),
    .tx_done_o   (tx_done_o),
    .fifo_level_o(fifo_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation ran out of time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Push one packet into an idle design and check that the line stays high
  // for two edges and then falls on edge N+2. Returns #1 after that edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    checkOutput("pushReady", 32'(in_ready_o), 32'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("latencyHighN", 32'(txd_o), 32'(1));
    @(negedge clk);
    checkOutput("latencyHighN1", 32'(txd_o), 32'(1));
    @(posedge clk);
    #1;
    checkOutput("latencyFallN2", 32'(txd_o), 32'(0));
  endtask

  // Wait, bounded, for the line to fall. Returns #1 after that edge.
  task automatic waitStart(input int bound);
    int  n;
    bit  seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < bound) begin
      @(posedge clk);
      #1;
      n++;
      if (txd_o == 1'b0) seen = 1'b1;
    end
    checkOutput("startSeen", 32'(seen), 32'(1));
  endtask

  // Entered #1 after the start edge S. Samples 30 bits mid-bit, checks the
  // framing, the bytes, busy and the tx_done pulse at S+120. If expectNext
  // is set, it also checks that the next start bit begins at S+121.
  task automatic recvFrame(input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] s, input bit expectNext);
    logic [29:0] bits;
    int          doneCnt;
    int          doneAt;
    bit          busyOk;
    bits    = '1;
    doneCnt = 0;
    doneAt  = -1;
    busyOk  = 1'b1;
    for (int t = 0; t <= 30 * CPB; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (t < 30 * CPB && (t % CPB) == CPB / 2) bits[t / CPB] = txd_o;
      if (tx_done_o) begin
        doneCnt++;
        doneAt = t;
      end
      if (t < 30 * CPB && !busy_o) busyOk = 1'b0;
    end
    checkOutput("framing", 32'({bits[0], bits[9], bits[10], bits[19], bits[20], bits[29]}),
                32'(6'b010101));
    checkOutput("byteAddr", 32'(bits[8:1]), 32'(a));
    checkOutput("byteData", 32'(bits[18:11]), 32'(d));
    checkOutput("byteSum", 32'(bits[28:21]), 32'(s));
    checkOutput("busyDuringFrame", 32'(busyOk), 32'(1));
    checkOutput("doneCount", 32'(doneCnt), 32'(1));
    checkOutput("doneCycle", 32'(doneAt), 32'(30 * CPB));
    checkOutput("idleCycleHigh", 32'(txd_o), 32'(1));
    checkOutput("busyLowAtEnd", 32'(busy_o), 32'(0));
    if (expectNext) begin
      @(posedge clk);
      #1;
      checkOutput("nextStartAfterOneIdle", 32'(txd_o), 32'(0));
    end
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_addr    = '0;
    in_data    = '0;

    vecs[0] = '{addr: 8'h35, data: 8'h01, sum: 8'h36};
    vecs[1] = '{addr: 8'hFF, data: 8'h02, sum: 8'h01};
    vecs[2] = '{addr: 8'h80, data: 8'h80, sum: 8'h00};
    vecs[3] = '{addr: 8'hA5, data: 8'h5A, sum: 8'hFF};

    bpAddr = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    bpData = '{8'h0F, 8'hE1, 8'h7C, 8'h99, 8'h02, 8'hB3};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetTxd", 32'(txd_o), 32'(1));
    checkOutput("resetBusy", 32'(busy_o), 32'(0));
    checkOutput("resetDone", 32'(tx_done_o), 32'(0));
    checkOutput("resetLevel", 32'(fifo_level_o), 32'(0));
    checkOutput("resetReady", 32'(in_ready_o), 32'(1));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data);
      recvFrame(vecs[i].addr, vecs[i].data, vecs[i].sum, 1'b0);
      repeat (3) @(posedge clk);
    end

    // Backpressure: in_valid stays high across six packets.
    fork
      begin : bpPusher
        int waits;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_addr  = bpAddr[i];
          in_data  = bpData[i];
          if (i == 5) begin
            checkOutput("bpReadyLowWhenFull", 32'(in_ready_o), 32'(0));
            checkOutput("bpLevelFull", 32'(fifo_level_o), 32'(DEPTH));
          end
          waits = 0;
          while (!in_ready_o && waits < 400) begin
            @(negedge clk);
            waits++;
          end
          if (i == 5) checkOutput("bpHoldCycles", 32'(waits), 32'(118));
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : bpReceiver
        waitStart(20);
        for (int i = 0; i < 6; i++)
          recvFrame(bpAddr[i], bpData[i], bpAddr[i] + bpData[i], i < 5);
      end
    join
    checkOutput("bpLevelEmpty", 32'(fifo_level_o), 32'(0));
    repeat (3) @(posedge clk);

    // A push on the same edge as the IDLE pop leaves the level at 1.
    applyStimulus(8'h11, 8'h22);
    fork
      begin : ppPusher
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 8'h33;
        in_data  = 8'h44;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (118) @(negedge clk);
        checkOutput("ppLevelBefore", 32'(fifo_level_o), 32'(1));
        in_valid = 1'b1;
        in_addr  = 8'h55;
        in_data  = 8'hC0;
        @(posedge clk);
        #1;
        checkOutput("ppLevelHeld", 32'(fifo_level_o), 32'(1));
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : ppReceiver
        recvFrame(8'h11, 8'h22, 8'h33, 1'b1);
        recvFrame(8'h33, 8'h44, 8'h77, 1'b1);
        recvFrame(8'h55, 8'hC0, 8'h15, 1'b0);
      end
    join
    repeat (3) @(posedge clk);

    // Reset during DATA bit 3 of byte1 with two packets queued.
    begin : midReset
      int lowCnt;
      int busyCnt;
      applyStimulus(8'h6B, 8'h9D);
      @(negedge clk);
      in_valid = 1'b1;
      in_addr  = 8'h01;
      in_data  = 8'h02;
      @(posedge clk);
      @(negedge clk);
      in_addr  = 8'h03;
      in_data  = 8'h04;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("mrLevelQueued", 32'(fifo_level_o), 32'(2));
      repeat (55) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mrTxd", 32'(txd_o), 32'(1));
      checkOutput("mrBusy", 32'(busy_o), 32'(0));
      checkOutput("mrLevel", 32'(fifo_level_o), 32'(0));
      checkOutput("mrReady", 32'(in_ready_o), 32'(1));
      @(negedge clk);
      reset   = 1'b0;
      lowCnt  = 0;
      busyCnt = 0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        #1;
        if (!txd_o) lowCnt++;
        if (busy_o) busyCnt++;
      end
      checkOutput("mrLineQuiet", 32'(lowCnt), 32'(0));
      checkOutput("mrStaysIdle", 32'(busyCnt), 32'(0));
    end

    applyStimulus(8'h12, 8'h34);
    recvFrame(8'h12, 8'h34, 8'h46, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
